pcie_rd_req_splitter: RTL and testbench
=======================================

PCIE_RD_REQ_SPLITTER -- requirements
Module: pcie_rd_req_splitter

Interface
REQ-001 SHALL have parameter MAX_RD_REQ_BYTES, default 512: maximum sub-request size in bytes; power of two, 64..4096.
REQ-002 SHALL have parameter NUM_TAGS, default 128: tag pool size; power of two.
REQ-003 SHALL have parameter ADDR_W, default 64: byte address width.
REQ-004 SHALL have parameter LEN_W, default 13: request length width in bytes; maximum length is 4096.
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports in_valid/in_ready, input/output, 1 each: parent read request handshake.
REQ-008 SHALL have ports in_addr (ADDR_W, input) and in_len (LEN_W, input): parent byte address and byte length; both DW-aligned.
REQ-009 SHALL have ports out_valid/out_ready, output/input, 1 each: sub-request handshake.
REQ-010 SHALL have ports out_addr (ADDR_W), out_len (LEN_W), out_tag (log2 NUM_TAGS) and out_last (1), all outputs: sub-request fields.
REQ-011 SHALL have ports cpl_valid (input, 1) and cpl_tag (input, log2 NUM_TAGS): final-completion notification that releases a tag.
REQ-012 SHALL have outputs outstanding (log2 NUM_TAGS + 1): tags in use; and err_dup_free (1): pulses when an already-free tag is released.

Function
REQ-013 SHALL implement states IDLE and SPLIT; in_ready is 1 only in IDLE.
REQ-014 SHALL, on an in handshake with in_len != 0, latch addr/remaining and enter SPLIT.
REQ-015 SHALL, on an in handshake with in_len == 0, emit nothing and remain in IDLE.
REQ-016 SHALL compute chunk = min(remaining, MAX_RD_REQ_BYTES - (addr mod MAX_RD_REQ_BYTES)), so no chunk crosses an MRRS or 4 KB boundary.
REQ-017 SHALL register every out_* field; out_valid rises no earlier than the cycle after the in handshake.
REQ-018 SHALL assign out_tag as the lowest-numbered free tag, marking it busy at the moment the chunk is loaded into the output register.
REQ-019 SHALL hold out_valid low while in SPLIT with no free tag, loading the chunk the cycle after a tag becomes free.
REQ-020 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on an out handshake with chunks remaining and a free tag, load the next chunk on the same edge so that out_valid stays 1 (one chunk per cycle).
REQ-022 SHALL set out_last=1 on the final chunk, and on that chunk's handshake return to IDLE.
REQ-023 SHALL free cpl_tag on the edge where cpl_valid=1; the freed tag is allocatable from the next cycle.
REQ-024 SHALL, when a free and an allocation occur in the same cycle, apply both, leaving outstanding unchanged.
REQ-025 SHALL, when cpl_valid names a tag already free, leave the pool unchanged and drive err_dup_free=1 for exactly one cycle.
REQ-026 SHALL keep outstanding equal to the popcount of busy tags, saturating at NUM_TAGS by construction.

Reset
REQ-027 SHALL, on rst assertion, immediately force state=IDLE, all tags free, out_valid=0, out_addr/out_len/out_tag/out_last=0, outstanding=0 and err_dup_free=0.
REQ-028 SHALL drive in_ready=1 from the first cycle after rst deasserts.
REQ-029 SHALL discard a parent request in progress when rst asserts mid-split; no further chunks are emitted.

Verification
REQ-030 SHALL cover: addr 0x1000, len 2048, out_ready=1 -> four back-to-back chunks of 512 at 0x1000/0x1200/0x1400/0x1600, tags 0..3, out_last on the 4th, outstanding=4.
REQ-031 SHALL cover: addr 0x10F0, len 64 -> chunk 0x10F0 len 16 tag 0, then chunk 0x1100 len 48 tag 1 with out_last=1.
REQ-032 SHALL cover: 128 tags in use, then cpl_tag=5 -> out_valid rises the following cycle with out_tag=5.
REQ-033 SHALL cover: out_ready held low 10 cycles mid-split -> out_* stable throughout, no tag consumed.
REQ-034 SHALL cover: cpl_tag=9 while tag 9 is free -> err_dup_free=1 for one cycle, outstanding unchanged.
REQ-035 SHALL cover: rst pulsed after the 2nd of 4 chunks -> out_valid=0 and outstanding=0 immediately, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/pcie_rd_req_splitter.sv
// Splits a parent PCIe memory-read request into MRRS-aligned sub-requests,
// tagging each with the lowest free tag from a pool released by completions.
module pcie_rd_req_splitter #(
    parameter int unsigned MAX_RD_REQ_BYTES = 512,
    parameter int unsigned NUM_TAGS         = 128,
    parameter int unsigned ADDR_W           = 64,
    parameter int unsigned LEN_W            = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [LEN_W-1:0]              in_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [LEN_W-1:0]              out_len,
    output logic [$clog2(NUM_TAGS)-1:0]   out_tag,
    output logic                          out_last,
    input  logic                          cpl_valid,
    input  logic [$clog2(NUM_TAGS)-1:0]   cpl_tag,
    output logic [$clog2(NUM_TAGS):0]     outstanding,
    output logic                          err_dup_free
);

    localparam int unsigned TAG_W  = $clog2(NUM_TAGS);
    localparam int unsigned CNT_W  = TAG_W + 1;
    localparam int unsigned MRRS_W = $clog2(MAX_RD_REQ_BYTES);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_busy_nxt;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [LEN_W-1:0]    r_out_len;
    logic [TAG_W-1:0]    r_out_tag;
    logic                r_out_last;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_err_dup_free;

    logic                w_free_any;
    logic [TAG_W-1:0]    w_free_tag;
    logic [LEN_W-1:0]    w_room;
    logic [LEN_W-1:0]    w_chunk;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_rel;
    logic                w_load;

    // Lowest-numbered free tag; a tag released this cycle is not yet visible here.
    always_comb begin
        w_free_any = 1'b0;
        w_free_tag = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_any = 1'b1;
                w_free_tag = TAG_W'(i);
            end
        end
    end

    // Room left before the next MRRS boundary (MRRS divides 4 KB, so 4 KB is honoured too).
    assign w_room   = LEN_W'(MAX_RD_REQ_BYTES) - LEN_W'(r_addr[MRRS_W-1:0]);
    assign w_chunk  = (r_rem < w_room) ? r_rem : w_room;
    assign w_in_hs  = in_valid && (r_state == IDLE);
    assign w_out_hs = r_out_valid && out_ready;
    assign w_rel    = cpl_valid && r_busy[cpl_tag];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_in_hs && (in_len != '0)) begin
                    w_state_nxt = SPLIT;
                end
            end
            SPLIT: begin
                w_load = (r_rem != '0) && w_free_any && (!r_out_valid || out_ready);
                if (w_out_hs && r_out_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_rel) begin
            w_busy_nxt[cpl_tag] = 1'b0;
        end
        if (w_load) begin
            w_busy_nxt[w_free_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_rem          <= '0;
            r_busy         <= '0;
            r_out_valid    <= 1'b0;
            r_out_addr     <= '0;
            r_out_len      <= '0;
            r_out_tag      <= '0;
            r_out_last     <= 1'b0;
            r_outstanding  <= '0;
            r_err_dup_free <= 1'b0;
        end else begin
            r_err_dup_free <= cpl_valid && !r_busy[cpl_tag];
            r_busy         <= w_busy_nxt;
            r_outstanding  <= r_outstanding + CNT_W'(w_load) - CNT_W'(w_rel);
            if (w_in_hs) begin
                r_addr <= in_addr;
                r_rem  <= in_len;
            end else if (w_load) begin
                r_addr <= r_addr + ADDR_W'(w_chunk);
                r_rem  <= r_rem - w_chunk;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_addr;
                r_out_len   <= w_chunk;
                r_out_tag   <= w_free_tag;
                r_out_last  <= (w_chunk == r_rem);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = r_out_valid;
    assign out_addr     = r_out_addr;
    assign out_len      = r_out_len;
    assign out_tag      = r_out_tag;
    assign out_last     = r_out_last;
    assign outstanding  = r_outstanding;
    assign err_dup_free = r_err_dup_free;

endmodule

// File: tb/tb_pcie_rd_req_splitter.sv
// Directed bench for pcie_rd_req_splitter: default instance plus a 256-byte MRRS instance.
module tb_pcie_rd_req_splitter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned LEN_W  = 13;
    localparam int unsigned TAG_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, out_valid, out_ready, out_last;
    logic [ADDR_W-1:0] in_addr, out_addr;
    logic [LEN_W-1:0]  in_len, out_len;
    logic [TAG_W-1:0]  out_tag, cpl_tag;
    logic              cpl_valid, err_dup_free;
    logic [TAG_W:0]    outstanding;

    logic              s_in_valid, s_in_ready, s_out_valid, s_out_last, s_err_dup_free;
    logic [ADDR_W-1:0] s_in_addr, s_out_addr;
    logic [LEN_W-1:0]  s_in_len, s_out_len;
    logic [TAG_W-1:0]  s_out_tag;
    logic [TAG_W:0]    s_outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    pcie_rd_req_splitter u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_len(out_len),
        .out_tag(out_tag), .out_last(out_last),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
        .outstanding(outstanding), .err_dup_free(err_dup_free)
    );

    pcie_rd_req_splitter #(.MAX_RD_REQ_BYTES(256)) u_dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_addr(s_in_addr), .in_len(s_in_len),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_addr(s_out_addr), .out_len(s_out_len),
        .out_tag(s_out_tag), .out_last(s_out_last),
        .cpl_valid(1'b0), .cpl_tag(7'd0),
        .outstanding(s_outstanding), .err_dup_free(s_err_dup_free)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_chunk(input string tag, input logic [63:0] a, input logic [63:0] l,
                               input logic [63:0] t, input logic [63:0] last);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".addr"},  out_addr, a);
        check_eq({tag, ".len"},   64'(out_len), l);
        check_eq({tag, ".tag"},   64'(out_tag), t);
        check_eq({tag, ".last"},  64'(out_last), last);
    endtask

    // All tasks below start and end at a falling edge.
    task automatic send_req(input logic [63:0] a, input logic [LEN_W-1:0] l);
        in_valid = 1'b1;
        in_addr  = a;
        in_len   = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic free_tag(input logic [TAG_W-1:0] t);
        cpl_valid = 1'b1;
        cpl_tag   = t;
        @(negedge clk);
        cpl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(in_ready && !out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(in_ready && !out_valid), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 1'b0; in_addr = '0; in_len = '0; out_ready = 1'b1;
        cpl_valid = 1'b0; cpl_tag = '0;
        s_in_valid = 1'b0; s_in_addr = '0; s_in_len = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst.out_valid",   64'(out_valid), 64'd0);
        check_eq("rst.outstanding", 64'(outstanding), 64'd0);
        check_eq("rst.err",         64'(err_dup_free), 64'd0);
        check_eq("rst.addr",        out_addr, 64'd0);
        check_eq("rst.tag",         64'(out_tag), 64'd0);
        check_eq("rst.last",        64'(out_last), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst.in_ready",    64'(in_ready), 64'd1);

        // 256-byte MRRS: 0x10F0 len 64 splits at 0x1100
        s_in_valid = 1'b1; s_in_addr = 64'h10F0; s_in_len = 13'd64;
        @(negedge clk);
        s_in_valid = 1'b0;
        @(negedge clk);
        check_eq("c031a.valid", 64'(s_out_valid), 64'd1);
        check_eq("c031a.addr",  s_out_addr, 64'h10F0);
        check_eq("c031a.len",   64'(s_out_len), 64'd16);
        check_eq("c031a.tag",   64'(s_out_tag), 64'd0);
        check_eq("c031a.last",  64'(s_out_last), 64'd0);
        @(negedge clk);
        check_eq("c031b.valid", 64'(s_out_valid), 64'd1);
        check_eq("c031b.addr",  s_out_addr, 64'h1100);
        check_eq("c031b.len",   64'(s_out_len), 64'd48);
        check_eq("c031b.tag",   64'(s_out_tag), 64'd1);
        check_eq("c031b.last",  64'(s_out_last), 64'd1);
        @(negedge clk);
        check_eq("c031.done",   64'(s_out_valid), 64'd0);
        check_eq("c031.outst",  64'(s_outstanding), 64'd2);
        check_eq("c031.ready",  64'(s_in_ready), 64'd1);

        // 2048 bytes at 0x1000: four back-to-back 512-byte chunks
        send_req(64'h1000, 13'd2048);
        check_eq("c030.in_ready", 64'(in_ready), 64'd0);
        check_eq("c030.early",    64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_chunk("c030", 64'h1000 + 64'(k) * 64'h200, 64'd512, 64'(k), 64'(k == 3));
        end
        @(negedge clk);
        check_eq("c030.done",  64'(out_valid), 64'd0);
        check_eq("c030.outst", 64'(outstanding), 64'd4);
        check_eq("c030.ready", 64'(in_ready), 64'd1);

        // Zero-length parent is swallowed
        send_req(64'h5000, 13'd0);
        check_eq("zero.ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_eq("zero.valid", 64'(out_valid), 64'd0);

        // Duplicate free of tag 9
        free_tag(7'd9);
        check_eq("dup.err",    64'(err_dup_free), 64'd1);
        check_eq("dup.outst",  64'(outstanding), 64'd4);
        @(negedge clk);
        check_eq("dup.err_lo", 64'(err_dup_free), 64'd0);
        check_eq("dup.outst2", 64'(outstanding), 64'd4);

        for (int t = 0; t < 4; t++) free_tag(7'(t));
        check_eq("free4.outst", 64'(outstanding), 64'd0);

        // Backpressure mid-split, then simultaneous free + allocate
        send_req(64'h2000, 13'd1536);
        @(negedge clk);
        check_chunk("c033a", 64'h2000, 64'd512, 64'd0, 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check_chunk("c033b", 64'h2200, 64'd512, 64'd1, 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_chunk("c033.hold", 64'h2200, 64'd512, 64'd1, 64'd0);
            check_eq("c033.outst", 64'(outstanding), 64'd2);
        end
        out_ready = 1'b1;
        free_tag(7'd0);
        check_chunk("c024", 64'h2400, 64'd512, 64'd2, 64'd1);
        check_eq("c024.outst", 64'(outstanding), 64'd2);
        @(negedge clk);
        check_eq("c033.done",  64'(out_valid), 64'd0);
        free_tag(7'd1);
        free_tag(7'd2);
        check_eq("free.outst", 64'(outstanding), 64'd0);

        // Exhaust all 128 tags, then release tag 5
        for (int r = 0; r < 16; r++) begin
            send_req(64'(r) * 64'h1000, 13'd4096);
            wait_idle("fill.idle");
        end
        check_eq("fill.outst", 64'(outstanding), 64'd128);
        send_req(64'h20000, 13'd512);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("c032.starved", 64'(out_valid), 64'd0);
        end
        free_tag(7'd5);
        check_eq("c032.not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_chunk("c032", 64'h20000, 64'd512, 64'd5, 64'd1);
        check_eq("c032.outst", 64'(outstanding), 64'd128);
        @(negedge clk);
        check_eq("c032.done",  64'(out_valid), 64'd0);
        for (int t = 0; t < 128; t++) free_tag(7'(t));
        check_eq("drain.outst", 64'(outstanding), 64'd0);
        check_eq("drain.err",   64'(err_dup_free), 64'd0);

        // Reset in the middle of a four-chunk split
        send_req(64'h3000, 13'd2048);
        @(negedge clk);
        check_chunk("c035a", 64'h3000, 64'd512, 64'd0, 64'd0);
        @(negedge clk);
        check_chunk("c035b", 64'h3200, 64'd512, 64'd1, 64'd0);
        @(negedge clk);
        check_chunk("c035c", 64'h3400, 64'd512, 64'd2, 64'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("c035.valid", 64'(out_valid), 64'd0);
        check_eq("c035.outst", 64'(outstanding), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("c035.ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check_eq("c035.quiet", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        send_req(64'h4000, 13'd64);
        @(negedge clk);
        check_chunk("post_rst", 64'h4000, 64'd64, 64'd0, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
